// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding and default watchdog limit.
// Used by wb_cmd_master and wb_cmd_watchdog.
package wb_cmd_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_cmd_watchdog.sv
// Bus-cycle watchdog: counts stalled cycles and flags the last allowed one.
// Only instantiated when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_cmd_watchdog
   import wb_cmd_master_pkg::*;
#(
   parameter int TW      = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [TW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TW'(1);
      end
   end

   // expire marks the TIMEOUT-th cycle of the bus request, counting from zero
   assign expire = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone initiator converting a valid/ready command stream into cyc/ack bus cycles with one response each.
// Optional watchdog abort is enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int DW      = 16,
   parameter int AW      = 16,
   parameter int TW      = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic          cmd_we,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_wdata,
   output logic          wb_we,
   output logic          wb_cyc,
   input  logic [DW-1:0] wb_rdata,
   input  logic          wb_ack,
   output logic          busy
);

   state_t state;
   state_t next_state;
   logic   accept;
   logic   bus_done;
   logic   expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      bus_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               next_state = ST_BUS;
            end
         end
         ST_BUS: begin
            if (wb_ack || expire) begin
               bus_done   = 1'b1;
               next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign accept    = cmd_valid && cmd_ready;
   assign wb_cyc    = (state == ST_BUS);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   // Request fields are only loaded on accept, so they stay put for the whole bus cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_addr   <= '0;
         wb_wdata  <= '0;
         wb_we     <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            wb_addr  <= cmd_addr;
            wb_wdata <= cmd_wdata;
            wb_we    <= cmd_we;
         end
         if (bus_done) begin
            rsp_rdata <= (wb_ack && !wb_we) ? wb_rdata : '0;
         end
      end
   end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   logic err_q;

   wb_cmd_watchdog #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .enable (wb_cyc && !wb_ack),
      .expire (expire)
   );

   // An ack arriving in the expiry cycle takes priority over the abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (bus_done) begin
         err_q <= !wb_ack;
      end
   end

   assign rsp_err = err_q;
`else
   logic [TW-1:0] unused_timeout;

   assign unused_timeout = TW'(TIMEOUT);
   assign expire         = 1'b0;
   assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed plan items plus randomized commands against a transaction-level model.
// Timeout scenarios run only when WB_CMD_MASTER_TIMEOUT_EN is defined.
module tb_wb_cmd_master;

   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int TW  = 8;
   localparam int TMO = 4;

   logic          clk;
   logic          rst;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          cmd_we;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_wdata;
   logic          wb_we;
   logic          wb_cyc;
   logic [DW-1:0] wb_rdata;
   logic          wb_ack;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] b2b_addr [4];
   logic [DW-1:0] rq [$];
   int            idx, seen, last_acc, low_run, t, n, rsp_cnt;
   logic          acc_now;
   logic [DW-1:0] exp_q;

   wb_cmd_master #(
      .DW      (DW),
      .AW      (AW),
      .TW      (TW),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_we    (cmd_we),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .wb_addr   (wb_addr),
      .wb_wdata  (wb_wdata),
      .wb_we     (wb_we),
      .wb_cyc    (wb_cyc),
      .wb_rdata  (wb_rdata),
      .wb_ack    (wb_ack),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full command: the model derives bus length, error and read data from the slave latency alone
   task automatic apply_stimulus(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic we,
                                 input int ack_lat, input int hold, input logic [DW-1:0] rdata);
      int            wait_n;
      int            len;
      int            exp_len;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
      exp_len = ack_lat;
      exp_err = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      if (ack_lat > TMO) begin
         exp_len = TMO;
         exp_err = 1'b1;
      end
`endif
      exp_rdata = (we || exp_err) ? '0 : rdata;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_we    = we;
      cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      wb_ack    = 1'b0;
      wait_n    = 0;
      while (!cmd_ready && wait_n < 50) begin
         tick();
         wait_n++;
      end
      check_output("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      cmd_we    = 1'($urandom);
      len = 0;
      while (wb_cyc && len < 600) begin
         len++;
         check_output("bus_hold", {wb_addr, wb_wdata, wb_we, cmd_ready}, {addr, wdata, we, 1'b0});
         wb_ack   = (len == ack_lat);
         wb_rdata = (len == ack_lat) ? rdata : DW'($urandom);
         tick();
      end
      wb_ack = 1'b0;
      check_output("cyc_len", len, exp_len);
      check_output("rsp_valid", rsp_valid, 1);
      check_output("rsp_rdata", rsp_rdata, exp_rdata);
      check_output("rsp_err", rsp_err, exp_err);
      for (int i = 0; i < hold; i++) begin
         wb_ack   = 1'($urandom);
         wb_rdata = DW'($urandom);
         tick();
         check_output("rsp_stall", {rsp_valid, rsp_err, rsp_rdata, wb_cyc, cmd_ready},
                      {1'b1, exp_err, exp_rdata, 1'b0, 1'b0});
      end
      wb_ack    = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_output("back_to_idle", {rsp_valid, wb_cyc, cmd_ready, busy}, 4'b0010);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_we    = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      wb_rdata  = '0;
      wb_ack    = 1'b0;
      #12;
      check_output("reset_ctrl", {wb_cyc, wb_we, rsp_valid, rsp_err, busy, cmd_ready}, 6'b000001);
      check_output("reset_data", {wb_addr, wb_wdata, rsp_rdata}, '0);
      #5 rst = 1'b0;
      tick();

      apply_stimulus(16'h1234, 16'h0F0F, 1'b0, 3, 0, 16'hBEEF);
      apply_stimulus(16'h0010, 16'hA5A5, 1'b1, 1, 0, 16'h3C3C);
      apply_stimulus(16'h2222, 16'h0000, 1'b0, 2, 5, 16'h5A5A);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      apply_stimulus(16'h4444, 16'h0000, 1'b0, 1000, 1, 16'h1111);
      apply_stimulus(16'h4446, 16'h0000, 1'b0, TMO, 1, 16'h2468);
`endif

      for (int k = 0; k < 24; k++) begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
         apply_stimulus(AW'($urandom), DW'($urandom), 1'($urandom), $urandom_range(1, TMO + 2),
                        $urandom_range(0, 3), DW'($urandom));
`else
         apply_stimulus(AW'($urandom), DW'($urandom), 1'($urandom), $urandom_range(1, 6),
                        $urandom_range(0, 3), DW'($urandom));
`endif
      end

      // Back-to-back stream with a zero-wait slave and an always-ready consumer
      b2b_addr  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      idx       = 0;
      seen      = 0;
      last_acc  = 0;
      low_run   = 0;
      t         = 0;
      rsp_cnt   = 0;
      rsp_ready = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = b2b_addr[0];
      cmd_valid = 1'b1;
      while ((seen < 4 || rsp_valid) && t < 100) begin
         acc_now = 1'b0;
         if (cmd_valid && cmd_ready) begin
            if (idx > 0) check_output("b2b_spacing", t - last_acc, 3);
            last_acc = t;
            acc_now  = 1'b1;
         end
         if (rsp_valid) begin
            exp_q = (rq.size() > 0) ? rq.pop_front() : '0;
            check_output("b2b_rsp_rdata", rsp_rdata, exp_q);
            rsp_cnt++;
         end
         if (wb_cyc) begin
            if (seen > 0) check_output("b2b_gap", low_run >= 2, 1);
            if (seen < 4) check_output("b2b_addr", wb_addr, b2b_addr[seen]);
            else check_output("b2b_cyc_count", seen + 1, 4);
            seen++;
            low_run  = 0;
            wb_ack   = 1'b1;
            wb_rdata = DW'($urandom);
            rq.push_back(wb_rdata);
         end else begin
            low_run++;
            wb_ack = 1'b0;
         end
         tick();
         t++;
         if (acc_now) begin
            idx++;
            if (idx < 4) cmd_addr = b2b_addr[idx];
            else cmd_valid = 1'b0;
         end
      end
      wb_ack    = 1'b0;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check_output("b2b_count", seen, 4);
      check_output("b2b_rsp_count", rsp_cnt, 4);

      // Asynchronous reset in the middle of a bus cycle
      cmd_addr  = 16'h7777;
      cmd_wdata = 16'h1357;
      cmd_we    = 1'b1;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      cmd_valid = 1'b0;
      check_output("rst_pre_cyc", wb_cyc, 1);
      tick();
      #2 rst = 1'b1;
      #1;
      check_output("rst_async", {wb_cyc, rsp_valid, busy, cmd_ready}, 4'b0001);
      #4 rst = 1'b0;
      tick();
      check_output("rst_release", {cmd_ready, wb_cyc, rsp_valid, wb_addr}, {1'b1, 1'b0, 1'b0, 16'h0000});
      apply_stimulus(16'h0ABC, 16'h0000, 1'b0, 2, 1, 16'hC0DE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-clock Wishbone initiator that turns a valid/ready command stream into Wishbone bus cycles and returns one response per command. It drives the slave-side port of the team's Wishbone fabric, including the cross-clock bridge, from command sources such as a UART or USB command decoder. Cycles follow the team's convention:
- `cyc` only, no `stb`;
- `cyc` held until `ack`;
- read data valid only in the `ack` cycle.

An optional watchdog aborts cycles that never complete.

## Interface
Parameters:
- `DW`, 16, data width
- `AW`, 16, address width
- `TW`, 8, watchdog counter width
- `TIMEOUT`, 255, max cycles `wb_cyc` stays high; 1 ≤ `TIMEOUT` < 2^`TW`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_addr`  in  AW  command address
- `cmd_wdata`  in  DW  command write data
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid` & `cmd_ready`
- `rsp_rdata`  out  DW  read data; 0 for writes and errors
- `rsp_err`  out  1  cycle aborted by watchdog
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when `rsp_valid` & `rsp_ready`
- `wb_addr`  out  AW  bus address, held stable while `wb_cyc`
- `wb_wdata`  out  DW  bus write data, held stable while `wb_cyc`
- `wb_we`  out  1  bus write enable
- `wb_cyc`  out  1  bus cycle request
- `wb_rdata`  in  DW  bus read data
- `wb_ack`  in  1  bus acknowledge
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch addr/wdata/we into output regs, go to BUS.
- BUS:
  - `wb_cyc`=1; addr/wdata/we constant.
  - On `wb_ack`:
    - capture `wb_rdata` into `rsp_rdata` if read, else load 0;
    - `rsp_err`=0;
    - go to RESP.
- RESP:
  - `rsp_valid`=1, `wb_cyc`=0.
  - On `rsp_ready`, go to IDLE.
- One outstanding command; no pipelining. `cmd_ready`=0 outside IDLE.
- `wb_ack` while `wb_cyc`=0 is ignored entirely.
- `cmd_valid` during BUS/RESP is held off; no loss, no double accept.

## Timing
- Reset values: state IDLE; `wb_cyc`, `wb_we`, `rsp_valid`, `rsp_err`, `busy` = 0; `wb_addr`, `wb_wdata`, `rsp_rdata` = 0; `cmd_ready`=1 once state is IDLE.
- Accept at edge N → `wb_cyc`=1 from N+1.
- `wb_ack` sampled high at edge M → `wb_cyc`=0 and `rsp_valid`=1 from M+1.
- Zero-wait slave (`ack` in first `cyc` cycle): `cyc` high exactly 1 cycle.
- `rsp_ready` already high: `rsp_valid` lasts 1 cycle; next accept possible the following cycle.
- `wb_cyc` is low for ≥2 cycles between bus cycles (RESP + IDLE). Command-to-command minimum is 3 cycles.
- `rsp_*` outputs stable while `rsp_valid` & !`rsp_ready`.
- Reset mid-cycle: `wb_cyc` and `rsp_valid` drop immediately (async); any pending response is lost.

## Configuration
- `WB_CMD_MASTER_TIMEOUT_EN` defined:
  - `TW`-bit counter cleared on entering BUS; increments each BUS cycle without `wb_ack`.
  - If count = `TIMEOUT`-1 and no `ack`: leave BUS with `rsp_err`=1 and `rsp_rdata`=0, so `wb_cyc` is high exactly `TIMEOUT` cycles.
  - `ack` in the expiry cycle wins: normal response, `rsp_err`=0.
- Undefined:
  - no counter; BUS waits indefinitely;
  - `rsp_err` tied 0;
  - `TW`/`TIMEOUT` unused.

## Structure
- Shared package/include `wb_cmd_master_pkg`: FSM state encodings (2-bit IDLE=0, BUS=1, RESP=2) and default `TIMEOUT`.
- One natural sub-module, `wb_cmd_watchdog`: counter, clear/enable in, `expire` out. Instantiated only under `WB_CMD_MASTER_TIMEOUT_EN`.

## Test plan
- Read 0x1234, slave acks after 3 cycles with rdata 0xBEEF → `wb_cyc` high 3 cycles, `wb_we`=0; `rsp_rdata`=0xBEEF, `rsp_err`=0.
- Write 0x0010 ← 0xA5A5, zero-wait ack → `wb_cyc` high 1 cycle, `wb_we`=1, `wb_wdata`=0xA5A5; `rsp_rdata`=0.
- Back-to-back commands, `cmd_valid` always 1, `rsp_ready`=1 → accepts spaced 3 cycles apart, `wb_cyc` low ≥2 cycles between, addresses in order.
- Timeout (macro on, `TIMEOUT`=4), no ack:
  - `wb_cyc` high exactly 4 cycles; `rsp_err`=1, `rsp_rdata`=0;
  - repeat with ack on the 4th cycle → `rsp_err`=0.
- `rsp_ready` held 0 for 5 cycles after completion → `rsp_valid` and data stable, `cmd_ready`=0; spurious `wb_ack` pulses ignored.
- `rst` pulsed during BUS → `wb_cyc`=0 immediately, after release `cmd_ready`=1, next command runs normally.
